// File: rtl/nios_security_sw_ctrl.sv
// Debounced switch input port for Nios II with edge capture and level irq.
// Avalon-MM slave: DATA, IRQMASK, PERIOD, EDGECAP at word addresses 0..3.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address, chipselect,  Avalon-MM slave (write_n active-low)
//   write_n, writedata,
//   readdata              registered read data, 1-cycle latency
//   in_port               raw asynchronous switch levels
//   irq                   registered OR of (EDGECAP & IRQMASK)
module nios_security_sw_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int STABLE_SAMPLES = 4,
    parameter int DEFAULT_PERIOD = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    localparam logic [2:0]  SS    = 3'(STABLE_SAMPLES);
    localparam logic [15:0] DEF_P = 16'(DEFAULT_PERIOD);

    logic                       rst_meta;
    logic                       rst_i;
    logic [DATA_WIDTH-1:0]      sync1;
    logic [DATA_WIDTH-1:0]      sync2;
    logic [DATA_WIDTH-1:0]      deb;
    logic [DATA_WIDTH-1:0]      deb_nx;
    logic [DATA_WIDTH-1:0]      edgecap;
    logic [DATA_WIDTH-1:0]      edge_nx;
    logic [DATA_WIDTH-1:0]      irqmask;
    logic [DATA_WIDTH-1:0][2:0] cnt;
    logic [DATA_WIDTH-1:0][2:0] cnt_nx;
    logic [15:0]                period;
    logic [15:0]                presc;
    logic                       tick;
    logic                       wr;
    logic                       wr_mask;
    logic                       wr_period;
    logic                       wr_edge;
    logic [DATA_WIDTH-1:0]      wd_dw;
    logic [31:0]                rd_nx;
    logic [31:0]                data_ext;
    logic [31:0]                mask_ext;
    logic [31:0]                edge_ext;
    logic                       unused_wd;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta <= 1'b0;
            rst_i    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_i    <= rst_meta;
        end
    end

    assign wr        = chipselect & ~write_n;
    assign wr_mask   = wr && (address == 2'd1);
    assign wr_period = wr && (address == 2'd2);
    assign wr_edge   = wr && (address == 2'd3);
    assign wd_dw     = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata[31:16];
    assign tick      = (presc == 16'd0);

    // Per-bit stability count; the bit flips on the tick that reaches
    // STABLE_SAMPLES and the count restarts from zero.
    always_comb begin
        deb_nx = deb;
        cnt_nx = cnt;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (tick) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] + 3'd1 == SS) begin
                        deb_nx[i] = ~deb[i];
                        cnt_nx[i] = 3'd0;
                    end else begin
                        cnt_nx[i] = cnt[i] + 3'd1;
                    end
                end else begin
                    cnt_nx[i] = 3'd0;
                end
            end
        end
    end

    // Set has priority over a simultaneous write-1-to-clear.
    always_comb begin
        edge_nx = edgecap & ~(wr_edge ? wd_dw : '0);
        edge_nx = edge_nx | (deb ^ deb_nx);
    end

    always_comb begin
        data_ext = '0;
        mask_ext = '0;
        edge_ext = '0;
        data_ext[DATA_WIDTH-1:0] = deb;
        mask_ext[DATA_WIDTH-1:0] = irqmask;
        edge_ext[DATA_WIDTH-1:0] = edgecap;
        case (address)
            2'd0:    rd_nx = data_ext;
            2'd1:    rd_nx = mask_ext;
            2'd2:    rd_nx = {16'h0000, period};
            default: rd_nx = edge_ext;
        endcase
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            cnt      <= '0;
            edgecap  <= '0;
            irqmask  <= '0;
            period   <= DEF_P;
            presc    <= DEF_P;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            sync1    <= in_port;
            sync2    <= sync1;
            deb      <= deb_nx;
            cnt      <= cnt_nx;
            edgecap  <= edge_nx;
            readdata <= rd_nx;
            irq      <= |(edgecap & irqmask);
            if (wr_mask) begin
                irqmask <= wd_dw;
            end
            // A PERIOD write restarts the countdown from the new value.
            if (wr_period) begin
                period <= writedata[15:0];
                presc  <= writedata[15:0];
            end else if (tick) begin
                presc <= period;
            end else begin
                presc <= presc - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_nios_security_sw_ctrl.sv
// Testbench for nios_security_sw_ctrl: directed scenarios plus random
// register/switch traffic compared against a behavioural model.
module tb_nios_security_sw_ctrl;

    localparam int DW = 16;
    localparam int SS = 4;
    localparam int DP = 50000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = 32'd0;
    logic [31:0]   readdata;
    logic [DW-1:0] in_port = '0;
    logic          irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nios_security_sw_ctrl #(
        .DATA_WIDTH(DW),
        .STABLE_SAMPLES(SS),
        .DEFAULT_PERIOD(DP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    // Behavioural model: sample history, tick countdown, per-bit counts.
    int            m_rel;
    int            m_cd;
    int            m_cnt [DW];
    int            m_period;
    logic [DW-1:0] m_s1, m_s2, m_deb, m_edge, m_mask, m_nd, m_clr;
    logic [31:0]   m_rd;
    logic          m_irq;
    logic          m_tick;
    logic          m_w;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rel = 0;
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            m_edge = '0; m_mask = '0;
            m_period = DP; m_cd = DP;
            m_rd = '0; m_irq = 1'b0;
            for (int i = 0; i < DW; i++) m_cnt[i] = 0;
        end else if (m_rel < 2) begin
            m_rel = m_rel + 1;
        end else begin
            m_w = chipselect && !write_n;
            if (address == 2'd0) m_rd = 32'(m_deb);
            else if (address == 2'd1) m_rd = 32'(m_mask);
            else if (address == 2'd2) m_rd = 32'(m_period);
            else m_rd = 32'(m_edge);
            m_irq = (m_edge & m_mask) != 0;
            m_tick = (m_cd == 0);
            m_nd = m_deb;
            if (m_tick) begin
                for (int i = 0; i < DW; i++) begin
                    if (m_s2[i] != m_deb[i]) begin
                        m_cnt[i] = m_cnt[i] + 1;
                        if (m_cnt[i] == SS) begin
                            m_nd[i] = ~m_deb[i];
                            m_cnt[i] = 0;
                        end
                    end else begin
                        m_cnt[i] = 0;
                    end
                end
            end
            if (m_w && address == 2'd2) m_cd = int'(writedata[15:0]);
            else if (m_tick) m_cd = m_period;
            else m_cd = m_cd - 1;
            m_clr = '0;
            if (m_w && address == 2'd1) m_mask = writedata[DW-1:0];
            if (m_w && address == 2'd2) m_period = int'(writedata[15:0]);
            if (m_w && address == 2'd3) m_clr = writedata[DW-1:0];
            m_edge = (m_edge & ~m_clr) | (m_nd ^ m_deb);
            m_deb = m_nd;
            m_s2 = m_s1;
            m_s1 = in_port;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        step();
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic test_reset();
        in_port = '0;
        reset_n = 1'b0;
        repeat (4) step();
        checks++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_held rd=%0h irq=%0b exp rd=0 irq=0", readdata, irq);
        end
        reset_n = 1'b1;
        repeat (4) step();
        address = 2'd0;
        step();
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_data got=%0h exp=0", readdata);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%0b exp=0", irq);
        end
        address = 2'd2;
        step();
        checks++;
        if (readdata !== 32'd50000) begin
            failures++;
            $display("FAIL reset_period got=%0d exp=50000", readdata);
        end
    endtask

    task automatic test_clean_press();
        int n;
        logic irq_seen;
        wr_reg(2'd2, 32'hABCD_0009);
        address = 2'd2;
        step();
        checks++;
        if (readdata !== 32'd9) begin
            failures++;
            $display("FAIL period_rb got=%0h exp=9", readdata);
        end
        in_port[3] = 1'b1;
        address = 2'd0;
        step();
        n = 0;
        irq_seen = 1'b0;
        while (n < 100 && readdata[3] !== 1'b1) begin
            step();
            n++;
            if (irq !== 1'b0) irq_seen = 1'b1;
        end
        checks++;
        if (n < 30 || n > 60) begin
            failures++;
            $display("FAIL press_latency got=%0d exp=30..60", n);
        end
        address = 2'd3;
        step();
        checks++;
        if (readdata !== 32'h0008) begin
            failures++;
            $display("FAIL press_edgecap got=%0h exp=8", readdata);
        end
        checks++;
        if (irq_seen !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL press_irq_masked got=%0b exp=0", irq_seen | irq);
        end
    endtask

    task automatic test_irq();
        int n;
        logic early;
        wr_reg(2'd3, 32'h0000_FFFF);
        wr_reg(2'd1, 32'hFFFF_0008);
        address = 2'd1;
        step();
        checks++;
        if (readdata !== 32'h0008) begin
            failures++;
            $display("FAIL irqmask_rb got=%0h exp=8", readdata);
        end
        in_port[3] = 1'b0;
        address = 2'd3;
        step();
        n = 0;
        early = 1'b0;
        while (n < 100 && readdata[3] !== 1'b1) begin
            if (irq !== 1'b0) early = 1'b1;
            step();
            n++;
        end
        checks++;
        if (n >= 100 || early !== 1'b0) begin
            failures++;
            $display("FAIL irq_wait n=%0d early=%0b exp n<100 early=0", n, early);
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_assert got=%0b exp=1", irq);
        end
        wr_reg(2'd3, 32'h0000_0008);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_hold got=%0b exp=1", irq);
        end
        address = 2'd3;
        step();
        checks++;
        if (irq !== 1'b0 || readdata !== 32'd0) begin
            failures++;
            $display("FAIL irq_clear irq=%0b rd=%0h exp irq=0 rd=0", irq, readdata);
        end
    endtask

    task automatic test_glitch();
        wr_reg(2'd2, 32'd0);
        wr_reg(2'd3, 32'h0000_FFFF);
        address = 2'd0;
        step();
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL glitch_base got=%0h exp=0", readdata);
        end
        in_port[0] = 1'b1;
        repeat (3) step();
        in_port[0] = 1'b0;
        repeat (10) step();
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL glitch_data got=%0h exp=0", readdata);
        end
        address = 2'd3;
        step();
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL glitch_edge got=%0h exp=0", readdata);
        end
    endtask

    task automatic test_collision();
        logic found;
        address = 2'd3;
        in_port[5] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (m_cnt[5] == SS - 1 && m_s2[5] != m_deb[5] && m_cd == 0) begin
                wr_reg(2'd3, 32'h0000_FFFF);
                found = 1'b1;
            end else begin
                step();
            end
        end
        checks++;
        if (found !== 1'b1) begin
            failures++;
            $display("FAIL collide_timing got=0 exp=1");
        end
        address = 2'd3;
        step();
        checks++;
        if (readdata !== 32'h0020) begin
            failures++;
            $display("FAIL set_wins got=%0h exp=20", readdata);
        end
        address = 2'd0;
        step();
        checks++;
        if (readdata !== 32'h0020) begin
            failures++;
            $display("FAIL collide_data got=%0h exp=20", readdata);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic found;
        wr_reg(2'd2, 32'd9);
        in_port[7] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            if (m_cnt[7] == 2) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            failures++;
            $display("FAIL mid_partial got=0 exp=1");
        end
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL mid_in_reset rd=%0h irq=%0b exp 0", readdata, irq);
        end
        reset_n = 1'b1;
        repeat (3) step();
        address = 2'd2;
        step();
        checks++;
        if (readdata !== 32'd50000) begin
            failures++;
            $display("FAIL mid_period got=%0d exp=50000", readdata);
        end
        address = 2'd0;
        step();
        checks++;
        if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL mid_data got=%0h exp=0", readdata);
        end
        wr_reg(2'd2, 32'd9);
        address = 2'd0;
        step();
        n = 0;
        while (n < 100 && readdata[7] !== 1'b1) begin
            step();
            n++;
        end
        checks++;
        if (n < 35 || n > 45) begin
            failures++;
            $display("FAIL mid_full_count got=%0d exp=35..45", n);
        end
        address = 2'd3;
        step();
        checks++;
        if (readdata !== 32'h00A0) begin
            failures++;
            $display("FAIL mid_edgecap got=%0h exp=a0", readdata);
        end
    endtask

    task automatic test_random();
        int idx;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                idx = $urandom_range(0, DW - 1);
                in_port[idx] = ~in_port[idx];
            end
            address = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n = 1'($urandom_range(0, 1));
            writedata = $urandom;
            if (address == 2'd2)
                writedata = (writedata & 32'hFFFF_0000) | $urandom_range(0, 3);
            reset_n = !(i >= 1500 && i < 1502);
            step();
            checks++;
            if (readdata !== m_rd) begin
                failures++;
                $display("FAIL rand_rd cyc=%0d got=%0h exp=%0h", i, readdata, m_rd);
            end
            checks++;
            if (irq !== m_irq) begin
                failures++;
                $display("FAIL rand_irq cyc=%0d got=%0b exp=%0b", i, irq, m_irq);
            end
        end
        chipselect = 1'b0;
        write_n = 1'b1;
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_irq();
        test_glitch();
        test_collision();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nios_security_sw_ctrl.md
NIOS_SECURITY_SW_CTRL -- requirements
Module: nios_security_sw_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: number of switch inputs.
REQ-002 Parameter STABLE_SAMPLES, default 4, range 1-7: consecutive equal samples needed to accept a new bit value.
REQ-003 Parameter DEFAULT_PERIOD, default 50000: reset value of PERIOD (1 ms at 50 MHz).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  2  Avalon-MM word address.
REQ-007 chipselect  input  1  Avalon-MM select.
REQ-008 write_n  input  1  Avalon-MM write strobe, active-low.
REQ-009 writedata  input  32  Avalon-MM write data.
REQ-010 readdata  output  32  Avalon-MM read data, registered.
REQ-011 in_port  input  DATA_WIDTH  raw asynchronous switch levels.
REQ-012 irq  output  1  level interrupt to Nios II, registered.

Function
REQ-013 Register map SHALL be: 0 DATA (RO, debounced levels); 1 IRQMASK (RW); 2 PERIOD (RW, bits 15:0); 3 EDGECAP (read; write-1-to-clear).
REQ-014 in_port SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 A 16-bit prescaler SHALL count down from PERIOD, assert a 1-cycle sample tick on reaching 0, and reload from PERIOD in the same cycle.
REQ-016 PERIOD = 0 SHALL produce a tick every cycle.
REQ-017 A write to PERIOD SHALL reload the prescaler with the new value on the cycle after the write.
REQ-018 Each bit SHALL have a 3-bit stability counter: on a tick, if the synchronized bit differs from the debounced bit, increment, else clear to 0.
REQ-019 When a counter reaches STABLE_SAMPLES on a tick, the debounced bit SHALL toggle and the counter SHALL clear in the same cycle.
REQ-020 A glitch shorter than STABLE_SAMPLES ticks SHALL NOT change DATA.
REQ-021 Any change (either edge) of a debounced bit SHALL set the matching EDGECAP bit on the cycle the debounced bit changes.
REQ-022 A write to EDGECAP SHALL clear every bit written as 1 and leave every bit written as 0 unchanged.
REQ-023 Simultaneous set and clear of one EDGECAP bit SHALL leave the bit set.
REQ-024 A write occurs only when chipselect=1 and write_n=0.
REQ-025 Writes to address 0 SHALL have no effect.
REQ-026 Register bits above DATA_WIDTH, and above bit 15 for PERIOD, SHALL be ignored on write.
REQ-027 Unused register bits SHALL read as 0.
REQ-028 readdata SHALL update every cycle from the current address, independent of chipselect, with 1-cycle latency.
REQ-029 Reads SHALL have no side effects.
REQ-030 irq SHALL equal the OR of (EDGECAP & IRQMASK), registered, so it appears 1 cycle after the causing register change.

Reset
REQ-031 While reset_n=0, readdata, irq, IRQMASK, EDGECAP, DATA, the synchronizers and all stability counters SHALL be 0.
REQ-032 While reset_n=0, PERIOD SHALL be DEFAULT_PERIOD and the prescaler SHALL be loaded with DEFAULT_PERIOD.
REQ-033 Reset assertion mid-debounce SHALL discard partial counts.
REQ-034 Release of reset SHALL take effect synchronously to clk.
REQ-035 Inputs that are high at reset release SHALL be accepted as normal edges after STABLE_SAMPLES ticks and SHALL set EDGECAP.

Verification
REQ-036 Reset check: reset with in_port=0 -> readdata=0, irq=0, read of address 2 returns 50000.
REQ-037 Clean press with PERIOD=9 and in_port[3] held high -> DATA bit 3 rises after 4 ticks plus sync, about 2+4*10 cycles; EDGECAP=0x0008; irq stays 0 while IRQMASK=0.
REQ-038 Interrupt path: IRQMASK=0x0008, then the REQ-037 press -> irq=1 one cycle after EDGECAP[3] sets; write 0x0008 to address 3 -> EDGECAP=0 and irq=0 the next cycle.
REQ-039 Glitch rejection: PERIOD=0, in_port[0] high for 3 cycles then low -> DATA and EDGECAP unchanged.
REQ-040 Set-wins collision: a write of 0xFFFF to address 3 in the same cycle as bit 5 debounces -> EDGECAP[5]=1 and all other bits 0.
REQ-041 Reset mid-operation: assert reset_n=0 after 2 of 4 ticks of a pending change -> after release, full STABLE_SAMPLES ticks are required again, and PERIOD is back to 50000.
